exhaustive_sweep: RTL and testbench



---
 rtl/exhaustive_sweep.sv | 125 ++++++++++++
 tb/tb_exhaustive_sweep.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/exhaustive_sweep.sv
// Truth-table sweeper: applies every N_IN-bit vector, waits SETTLE extra cycles, samples f and
// compares against a latched expected table. Define SWEEP_GRAY_EN for reflected Gray vector order.
module exhaustive_sweep #(
    parameter int N_IN   = 4,
    parameter int SETTLE = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   start_i,
    input  logic [(1<<N_IN)-1:0]   expected_i,
    input  logic                   f_i,
    output logic [N_IN-1:0]        vec_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [(1<<N_IN)-1:0]   table_o,
    output logic                   pass_o,
    output logic [N_IN:0]          err_count_o
);

    // state  | meaning
    // IDLE   | waiting for start, results of last sweep held
    // HOLD   | vector applied, counting settle cycles, sample on terminal count
    // FINISH | one-cycle done pulse, pass valid
    typedef enum logic [1:0] {IDLE, HOLD, FINISH} state_t;

    localparam int NV = 1 << N_IN;

    state_t            state_q, state_d;
    logic [N_IN-1:0]   idx_q, idx_d;
    logic [3:0]        hold_q, hold_d;
    logic [NV-1:0]     exp_q, exp_d;
    logic [NV-1:0]     table_q, table_d;
    logic [N_IN:0]     err_q, err_d;
    logic              pass_q, pass_d;
    logic [N_IN-1:0]   vec_cur;
    logic [N_IN:0]     err_nxt;

    // idx_q always counts in binary; the applied vector is derived from it.
`ifdef SWEEP_GRAY_EN
    assign vec_cur = idx_q ^ (idx_q >> 1);
`else
    assign vec_cur = idx_q;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            hold_q  <= '0;
            exp_q   <= '0;
            table_q <= '0;
            err_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            exp_q   <= exp_d;
            table_q <= table_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        exp_d   = exp_q;
        table_d = table_q;
        err_d   = err_q;
        pass_d  = pass_q;
        err_nxt = err_q;

        // An X/Z on f fails the equality and lands in the mismatch branch.
        if (f_i == exp_q[vec_cur]) begin
            err_nxt = err_q;
        end else begin
            err_nxt = err_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    exp_d   = expected_i;
                    table_d = '0;
                    err_d   = '0;
                    pass_d  = 1'b0;
                    idx_d   = '0;
                    hold_d  = 4'(SETTLE);
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (hold_q != 4'd0) begin
                    hold_d = hold_q - 1'b1;
                end else begin
                    table_d[vec_cur] = f_i;
                    err_d            = err_nxt;
                    if (idx_q == {N_IN{1'b1}}) begin
                        pass_d  = (err_nxt == '0);
                        state_d = FINISH;
                    end else begin
                        idx_d  = idx_q + 1'b1;
                        hold_d = 4'(SETTLE);
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign vec_o       = vec_cur;
    assign busy_o      = (state_q == HOLD);
    assign done_o      = (state_q == FINISH);
    assign table_o     = table_q;
    assign pass_o      = pass_q;
    assign err_count_o = err_q;

endmodule

// File: tb/tb_exhaustive_sweep.sv
// Scoreboard bench for exhaustive_sweep: two instances (SETTLE=1 and SETTLE=0) sweep f = A&B | C.
// Expected results are queued at start acceptance and checked by monitors on each done pulse.
module tb_exhaustive_sweep;

    typedef struct {
        logic [15:0] tbl;
        logic        pass;
        logic [4:0]  err;
        int          t0;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, rst_n0;
    logic        start, start0;
    logic [15:0] expected, expected0;
    logic        f, f0;
    logic [3:0]  vec, vec0;
    logic        busy, busy0, done, done0, pass, pass0;
    logic [15:0] tbl, tbl0;
    logic [4:0]  err, err0;

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   busy_cnt = 0, busy_cnt0 = 0;
    int   dones1 = 0;
    exp_t q1[$];
    exp_t q0[$];
    logic [3:0] vlog[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference function under test: f = A&B | C, A = vec[3]
    assign f  = (vec[3]  & vec[2])  | vec[1];
    assign f0 = (vec0[3] & vec0[2]) | vec0[1];

    exhaustive_sweep #(.N_IN(4), .SETTLE(1)) u_dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .expected_i(expected), .f_i(f),
        .vec_o(vec), .busy_o(busy), .done_o(done), .table_o(tbl), .pass_o(pass), .err_count_o(err));

    exhaustive_sweep #(.N_IN(4), .SETTLE(0)) u_dut0 (
        .clk_i(clk), .rst_n_i(rst_n0), .start_i(start0), .expected_i(expected0), .f_i(f0),
        .vec_o(vec0), .busy_o(busy0), .done_o(done0), .table_o(tbl0), .pass_o(pass0), .err_count_o(err0));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check_reset1(input string tag);
        chk({tag, "_vec"},  32'(vec),  0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_table"}, 32'(tbl), 0);
        chk({tag, "_pass"}, 32'(pass), 0);
        chk({tag, "_err"},  32'(err),  0);
    endtask

    // Monitor for SETTLE=1 instance
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                dones1++;
                if (q1.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = q1.pop_front();
                    chk("table",   32'(tbl),  32'(e.tbl));
                    chk("pass",    32'(pass), 32'(e.pass));
                    chk("err_cnt", 32'(err),  32'(e.err));
                    chk("latency", cyc - e.t0, e.lat);
                    chk("busy_len", busy_cnt, e.lat);
                end
                busy_cnt = 0;
            end
        end
    end

    // Monitor for SETTLE=0 instance, also logs the applied vector sequence
    always @(negedge clk) begin
        if (!rst_n0) begin
            busy_cnt0 = 0;
            vlog.delete();
        end else begin
            if (busy0) begin
                busy_cnt0++;
                vlog.push_back(vec0);
            end
            if (done0) begin
                if (q0.size() == 0) begin
                    chk("unexpected_done0", 1, 0);
                end else begin
                    exp_t e;
                    int bad;
                    e = q0.pop_front();
                    chk("table0",    32'(tbl0),  32'(e.tbl));
                    chk("pass0",     32'(pass0), 32'(e.pass));
                    chk("err_cnt0",  32'(err0),  32'(e.err));
                    chk("latency0",  cyc - e.t0, e.lat);
                    chk("busy_len0", busy_cnt0, e.lat);
                    chk("vec_count0", vlog.size(), 16);
                    bad = 0;
`ifdef SWEEP_GRAY_EN
                    if (vlog.size() >= 5) begin
                        if (vlog[0] != 4'd0 || vlog[1] != 4'd1 || vlog[2] != 4'd3 ||
                            vlog[3] != 4'd2 || vlog[4] != 4'd6) bad++;
                    end else bad++;
                    for (int i = 1; i < vlog.size(); i++)
                        if ($countones(vlog[i] ^ vlog[i-1]) != 1) bad++;
                    chk("gray_seq0", bad, 0);
`else
                    for (int i = 0; i < vlog.size(); i++)
                        if (32'(vlog[i]) != i) bad++;
                    chk("bin_seq0", bad, 0);
`endif
                end
                busy_cnt0 = 0;
                vlog.delete();
            end
        end
    end

    task automatic push1(input logic [15:0] t, input logic p, input logic [4:0] e);
        exp_t x;
        x.tbl = t; x.pass = p; x.err = e; x.t0 = cyc; x.lat = 32;
        q1.push_back(x);
    endtask

    task automatic start1(input logic [15:0] ex, input logic [15:0] t, input logic p, input logic [4:0] e);
        expected = ex;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        push1(t, p, e);
    endtask

    task automatic drain(input int which);
        int n;
        n = 0;
        while (((which == 1) ? q1.size() : q0.size()) != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("drain_timeout", 1, 0);
        @(negedge clk);
    endtask

    initial begin
        exp_t x;
        int   n;
        int   d_before;
        rst_n = 1'b0; rst_n0 = 1'b0;
        start = 1'b0; start0 = 1'b0;
        expected = '0; expected0 = '0;
        repeat (3) @(negedge clk);
        check_reset1("rst");
        chk("rst_busy0", 32'(busy0), 0);
        chk("rst_err0",  32'(err0),  0);
        rst_n = 1'b1; rst_n0 = 1'b1;
        @(negedge clk);

        // Matching sweep; expected changed mid-sweep must be ignored
        start1(16'hFCCC, 16'hFCCC, 1'b1, 5'd0);
        repeat (3) @(negedge clk);
        expected = 16'h0000;
        drain(1);

        // Two mismatching vectors
        start1(16'hFCCF, 16'hFCCC, 1'b0, 5'd2);
        drain(1);

        // SETTLE=0 sweep, then start held from the FINISH cycle into IDLE
        expected0 = 16'hFCCC;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        x.tbl = 16'hFCCC; x.pass = 1'b1; x.err = 5'd0; x.t0 = cyc; x.lat = 16;
        q0.push_back(x);
        n = 0;
        while (!done0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("done0_seen", 32'(done0), 1);
        start0 = 1'b1;
        @(negedge clk);
        chk("start_in_finish_ignored", 32'(busy0), 0);
        @(negedge clk);
        chk("start_after_finish_taken", 32'(busy0), 1);
        start0 = 1'b0;
        x.t0 = cyc;
        q0.push_back(x);
        drain(0);

        // Robustness: start mid-sweep ignored, then reset at cycle 10
        start1(16'hFCCC, 16'hFCCC, 1'b1, 5'd0);
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_mid", 32'(busy), 1);
        repeat (4) @(negedge clk);
        d_before = dones1;
        rst_n = 1'b0;
        @(negedge clk);
        check_reset1("midrst");
        q1.delete();
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("no_done_after_reset", dones1 - d_before, 0);

        // Fresh sweep after reset completes normally
        start1(16'hFCCC, 16'hFCCC, 1'b1, 5'd0);
        drain(1);
        chk("pass_held", 32'(pass), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
